shift_unit_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle 32-bit arithmetic right shifter. It supports four shift modes (logical left, logical right, arithmetic right, rotate right) at any power-of-two WIDTH. Pipeline registers sit between groups of mux levels, and the block uses a valid/ready handshake with full backpressure. It sits between the ALU operand mux and the execute writeback, with a tag carried alongside each operation.

---
 rtl/shift_unit_pipe_pkg.sv | 14 +
 rtl/shift_unit_pipe_if.sv | 29 ++
 rtl/shift_unit_pipe_levels.sv | 27 ++
 rtl/shift_unit_pipe.sv | 105 ++++++++++
 tb/tb_shift_unit_pipe.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_unit_pipe_pkg.sv
// shift_pkg: shared op encoding and stage-count helper for the pipelined shifter
package shift_pkg;
    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    // Number of pipeline stages: one per group of per_stage mux levels.
    function automatic int clog2_ceil_div(int width, int per_stage);
        return ($clog2(width) + per_stage - 1) / per_stage;
    endfunction
endpackage

// File: rtl/shift_unit_pipe_if.sv
// shift_unit_pipe_if: operand/result handshake bundle of the pipelined shifter
interface shift_unit_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    import shift_pkg::*;
    localparam int SHW = $clog2(WIDTH);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    op_t              in_op;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_zero
    );
    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, flush, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_zero
    );
endinterface

// File: rtl/shift_unit_pipe_levels.sv
// shift_levels: NLEVELS consecutive shifter mux levels starting at level FIRST_LEVEL
module shift_levels import shift_pkg::*; #(
    parameter int WIDTH       = 32,
    parameter int FIRST_LEVEL = 0,
    parameter int NLEVELS     = 2
) (
    input  logic [WIDTH-1:0]   data_i,
    input  logic [NLEVELS-1:0] shamt_i,
    input  op_t                op_i,
    input  logic               sign_i,
    output logic [WIDTH-1:0]   data_o
);
    // One level: move by n bits; SRA fills with the sign captured at the input.
    function automatic logic [WIDTH-1:0] step(logic [WIDTH-1:0] d, op_t op, logic sign, int n);
        return op == OP_SLL ? d << n
             : op == OP_ROR ? (d >> n) | (d << (WIDTH - n))
             : (d >> n) | ((op == OP_SRA && sign) ? ~({WIDTH{1'b1}} >> n) : '0);
    endfunction

    // Apply the levels LSB-first; level j moves the data by 2^j when its shamt bit is set.
    always_comb begin
        data_o = data_i;
        for (int j = 0; j < NLEVELS; j++) begin
            if (shamt_i[j]) data_o = step(data_o, op_i, sign_i, 1 << (FIRST_LEVEL + j));
        end
    end
endmodule

// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: pipelined SLL/SRL/SRA/ROR unit with valid/ready backpressure and flush
module shift_unit_pipe import shift_pkg::*; #(
    parameter int WIDTH            = 32,
    parameter int LEVELS_PER_STAGE = 2,
    parameter int TAG_W            = 5
) (
    input logic              clock,
    input logic              reset,
    shift_unit_pipe_if.slave bus
);
    localparam int SHW  = $clog2(WIDTH);
    localparam int NSTG = clog2_ceil_div(WIDTH, LEVELS_PER_STAGE);

    logic [WIDTH-1:0] src_data  [NSTG];
    logic [WIDTH-1:0] lvl_data  [NSTG];
    logic [WIDTH-1:0] data_d    [NSTG];
    logic [WIDTH-1:0] data_q    [NSTG];
    logic [SHW-1:0]   src_shamt [NSTG];
    logic [SHW-1:0]   shamt_d   [NSTG];
    logic [SHW-1:0]   shamt_q   [NSTG];
    op_t              src_op    [NSTG];
    op_t              op_d      [NSTG];
    op_t              op_q      [NSTG];
    logic [TAG_W-1:0] src_tag   [NSTG];
    logic [TAG_W-1:0] tag_d     [NSTG];
    logic [TAG_W-1:0] tag_q     [NSTG];
    logic             src_sign  [NSTG];
    logic             sign_d    [NSTG];
    logic             sign_q    [NSTG];
    logic             src_valid [NSTG];
    logic             valid_d   [NSTG];
    logic             valid_q   [NSTG];
    logic             zero_d, zero_q, stall;

    assign stall         = valid_q[NSTG-1] & ~bus.out_ready;
    assign bus.in_ready  = ~reset & ~stall & ~bus.flush;
    assign bus.out_valid = valid_q[NSTG-1];
    assign bus.out_data  = data_q[NSTG-1];
    assign bus.out_tag   = tag_q[NSTG-1];
    assign bus.out_zero  = zero_q;

    // Stage inputs: stage 0 reads the port, later stages read the previous stage register.
    always_comb begin
        src_data[0]  = bus.in_data;
        src_shamt[0] = bus.in_shamt;
        src_op[0]    = bus.in_op;
        src_tag[0]   = bus.in_tag;
        src_sign[0]  = bus.in_data[WIDTH-1];
        src_valid[0] = bus.in_valid & bus.in_ready;
        for (int s = 1; s < NSTG; s++) begin
            src_data[s]  = data_q[s-1];
            src_shamt[s] = shamt_q[s-1];
            src_op[s]    = op_q[s-1];
            src_tag[s]   = tag_q[s-1];
            src_sign[s]  = sign_q[s-1];
            src_valid[s] = valid_q[s-1];
        end
    end

    for (genvar g = 0; g < NSTG; g++) begin : g_stage
        localparam int FIRST = g * LEVELS_PER_STAGE;
        localparam int NL    = (SHW - FIRST < LEVELS_PER_STAGE) ? SHW - FIRST : LEVELS_PER_STAGE;
        shift_levels #(.WIDTH(WIDTH), .FIRST_LEVEL(FIRST), .NLEVELS(NL)) u_levels (
            .data_i (src_data[g]),
            .shamt_i(src_shamt[g][FIRST +: NL]),
            .op_i   (src_op[g]),
            .sign_i (src_sign[g]),
            .data_o (lvl_data[g])
        );
    end

    // All stages advance together unless the output is stalled; flush kills every valid.
    always_comb begin
        for (int s = 0; s < NSTG; s++) begin
            data_d[s]  = stall ? data_q[s]  : lvl_data[s];
            shamt_d[s] = stall ? shamt_q[s] : src_shamt[s];
            op_d[s]    = stall ? op_q[s]    : src_op[s];
            tag_d[s]   = stall ? tag_q[s]   : src_tag[s];
            sign_d[s]  = stall ? sign_q[s]  : src_sign[s];
            valid_d[s] = bus.flush ? 1'b0 : stall ? valid_q[s] : src_valid[s];
        end
        zero_d = stall ? zero_q : (lvl_data[NSTG-1] == '0);
    end

    // Stage registers; reset clears everything, including the visible result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q  <= '{default: '0};
            shamt_q <= '{default: '0};
            op_q    <= '{default: OP_SLL};
            tag_q   <= '{default: '0};
            sign_q  <= '{default: 1'b0};
            valid_q <= '{default: 1'b0};
            zero_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            sign_q  <= sign_d;
            valid_q <= valid_d;
            zero_q  <= zero_d;
        end
    end
endmodule

// File: tb/tb_shift_unit_pipe.sv
// tb_shift_unit_pipe: scoreboard bench for the pipelined shifter at three geometries
module tb_shift_unit_pipe;
    import shift_pkg::*;

    typedef struct {
        logic [63:0] d;
        logic [4:0]  t;
        logic        z;
        int          acc;
        bit          lat;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int checks = 0, failures = 0, cyc = 0;
    int nst [3] = '{3, 2, 3};
    int acc_n [3];
    int last_acc [3];
    exp_t q [3][$];
    logic pv [3];
    logic [63:0] pd [3];
    logic [4:0] pt [3];
    logic pz [3];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    shift_unit_pipe_if #(.WIDTH(32), .TAG_W(5)) b32();
    shift_unit_pipe_if #(.WIDTH(64), .TAG_W(5)) b64();
    shift_unit_pipe_if #(.WIDTH(8),  .TAG_W(5)) b8();

    shift_unit_pipe #(.WIDTH(32), .LEVELS_PER_STAGE(2), .TAG_W(5)) u32 (.clock(clock), .reset(reset), .bus(b32.slave));
    shift_unit_pipe #(.WIDTH(64), .LEVELS_PER_STAGE(3), .TAG_W(5)) u64 (.clock(clock), .reset(reset), .bus(b64.slave));
    shift_unit_pipe #(.WIDTH(8),  .LEVELS_PER_STAGE(1), .TAG_W(5)) u8  (.clock(clock), .reset(reset), .bus(b8.slave));

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic set_in(int s, logic v, logic [63:0] d, int sh, op_t op, logic [4:0] t);
        case (s)
            0: begin b32.in_valid = v; b32.in_data = d[31:0]; b32.in_shamt = sh[4:0]; b32.in_op = op; b32.in_tag = t; end
            1: begin b64.in_valid = v; b64.in_data = d;       b64.in_shamt = sh[5:0]; b64.in_op = op; b64.in_tag = t; end
            default: begin b8.in_valid = v; b8.in_data = d[7:0]; b8.in_shamt = sh[2:0]; b8.in_op = op; b8.in_tag = t; end
        endcase
    endtask

    function automatic logic rdy(int s);
        return s == 0 ? b32.in_ready : s == 1 ? b64.in_ready : b8.in_ready;
    endfunction

    task automatic send(int s, logic [63:0] d, int sh, op_t op, logic [4:0] t, logic [63:0] e, bit lat);
        exp_t x;
        logic a;
        int n = 0;
        set_in(s, 1'b1, d, sh, op, t);
        do begin
            @(negedge clock);
            a = rdy(s);
            @(posedge clock);
            #1;
            n++;
        end while (!a && n < 40);
        chk("accept", 64'(a), 64'd1);
        if (a) begin
            x.d = e; x.t = t; x.z = (e == 64'd0); x.acc = cyc; x.lat = lat;
            q[s].push_back(x);
            acc_n[s]++;
            last_acc[s] = cyc;
        end
    endtask

    task automatic idle(int s);
        set_in(s, 1'b0, 64'd0, 0, OP_SLL, 5'd0);
    endtask

    task automatic drain(int s);
        int n = 0;
        while (q[s].size() != 0 && n < 30) begin
            @(posedge clock);
            n++;
        end
        chk("drain", 64'(q[s].size()), 64'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic mon(int s, logic v, logic r, logic [63:0] d, logic [4:0] t, logic z);
        exp_t x;
        if (v && !r && pv[s]) begin
            chk("stall_hold_data", d, pd[s]);
            chk("stall_hold_tag", 64'(t), 64'(pt[s]));
            chk("stall_hold_zero", 64'(z), 64'(pz[s]));
        end
        pv[s] = v && !r; pd[s] = d; pt[s] = t; pz[s] = z;
        if (v && r) begin
            if (q[s].size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out dut=%0d actual_data=%h required=no_result (t=%0t)", s, d, $time);
            end else begin
                x = q[s].pop_front();
                chk("out_data", d, x.d);
                chk("out_tag", 64'(t), 64'(x.t));
                chk("out_zero", 64'(z), 64'(x.z));
                if (x.lat) chk("latency", 64'(cyc - x.acc), 64'(nst[s] - 1));
            end
        end
    endtask

    always @(negedge clock) begin
        mon(0, b32.out_valid, b32.out_ready, 64'(b32.out_data), b32.out_tag, b32.out_zero);
        mon(1, b64.out_valid, b64.out_ready, b64.out_data, b64.out_tag, b64.out_zero);
        mon(2, b8.out_valid,  b8.out_ready,  64'(b8.out_data),  b8.out_tag,  b8.out_zero);
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int rc;
        for (int s = 0; s < 3; s++) idle(s);
        b32.flush = 0; b64.flush = 0; b8.flush = 0;
        b32.out_ready = 1; b64.out_ready = 1; b8.out_ready = 1;
        #1 reset = 1'b1;
        #2;
        chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
        chk("rst_out_data", 64'(b32.out_data), 64'd0);
        chk("rst_out_tag", 64'(b32.out_tag), 64'd0);
        chk("rst_out_zero", 64'(b32.out_zero), 64'd0);
        chk("rst_in_ready", 64'(b32.in_ready), 64'd0);
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        @(posedge clock);
        #1;
        chk("in_ready_after_rst", 64'(b32.in_ready), 64'd1);

        send(0, 64'h80000000, 31, OP_SRA, 5'd1, 64'hFFFFFFFF, 1);
        idle(0); drain(0);
        send(0, 64'h7FFFFFF0, 4, OP_SRA, 5'd2, 64'h07FFFFFF, 1);
        idle(0); drain(0);

        send(0, 64'h0000000F, 28, OP_SLL, 5'd1, 64'hF0000000, 1);
        send(0, 64'h80000000, 4,  OP_SRL, 5'd2, 64'h08000000, 1);
        send(0, 64'h00000001, 1,  OP_ROR, 5'd3, 64'h80000000, 1);
        idle(0); drain(0);

        send(0, 64'hDEADBEEF, 0,  OP_SLL, 5'd4,  64'hDEADBEEF, 1);
        send(0, 64'hDEADBEEF, 0,  OP_SRL, 5'd5,  64'hDEADBEEF, 1);
        send(0, 64'hDEADBEEF, 0,  OP_SRA, 5'd6,  64'hDEADBEEF, 1);
        send(0, 64'hDEADBEEF, 0,  OP_ROR, 5'd7,  64'hDEADBEEF, 1);
        send(0, 64'h00000001, 1,  OP_SRL, 5'd8,  64'h00000000, 1);
        send(0, 64'hF0000000, 8,  OP_SRA, 5'd9,  64'hFFF00000, 1);
        send(0, 64'h12345678, 12, OP_ROR, 5'd10, 64'h67812345, 1);
        send(0, 64'h12345678, 5,  OP_SLL, 5'd11, 64'h468ACF00, 1);
        send(0, 64'h80000001, 31, OP_SRL, 5'd12, 64'h00000001, 1);
        send(0, 64'h80000001, 31, OP_ROR, 5'd13, 64'h00000003, 1);
        idle(0); drain(0);

        b32.out_ready = 0;
        acc_n[0] = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(0, 64'h1, i, OP_SLL, 5'(14 + i), 64'h1 << i, 0);
                idle(0);
            end
            begin
                repeat (6) @(posedge clock);
                #2;
                chk("stall_accepted", 64'(acc_n[0]), 64'd3);
                chk("stall_in_ready", 64'(b32.in_ready), 64'd0);
                rc = cyc;
                b32.out_ready = 1;
                #1 chk("resume_in_ready", 64'(b32.in_ready), 64'd1);
            end
        join
        chk("resume_no_gap", 64'(last_acc[0]), 64'(rc + 2));
        chk("stall_all_accepted", 64'(acc_n[0]), 64'd5);
        drain(0);

        send(0, 64'h80000000, 1, OP_SRA, 5'd20, 64'hC0000000, 0);
        send(0, 64'h00000010, 4, OP_SRL, 5'd21, 64'h00000001, 0);
        send(0, 64'h00000001, 2, OP_SLL, 5'd22, 64'h00000004, 0);
        b32.flush = 1;
        set_in(0, 1'b1, 64'hFFFF, 0, OP_SLL, 5'd23);
        @(negedge clock);
        chk("flush_in_ready", 64'(b32.in_ready), 64'd0);
        @(posedge clock);
        #1;
        b32.flush = 0;
        idle(0);
        q[0].delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("flush_quiet", 64'(b32.out_valid), 64'd0);
        end
        @(posedge clock);
        #1;
        send(0, 64'h0000000F, 4, OP_ROR, 5'd24, 64'hF0000000, 1);
        idle(0); drain(0);

        b32.out_ready = 0;
        send(0, 64'h00000003, 1, OP_SLL, 5'd25, 64'h00000006, 0);
        idle(0);
        repeat (3) @(negedge clock);
        chk("stalled_valid", 64'(b32.out_valid), 64'd1);
        b32.flush = 1;
        @(posedge clock);
        #1;
        b32.flush = 0;
        q[0].delete();
        chk("flush_over_stall", 64'(b32.out_valid), 64'd0);
        b32.out_ready = 1;

        send(0, 64'h00000100, 8, OP_SRL, 5'd26, 64'h1, 0);
        send(0, 64'h00000200, 8, OP_SRL, 5'd27, 64'h2, 0);
        send(0, 64'h00000300, 8, OP_SRL, 5'd28, 64'h3, 0);
        idle(0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(b32.out_valid), 64'd0);
        chk("async_rst_in_ready", 64'(b32.in_ready), 64'd0);
        for (int s = 0; s < 3; s++) q[s].delete();
        #21 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("post_rst_quiet", 64'(b32.out_valid), 64'd0);
        end
        @(posedge clock);
        #1;
        send(0, 64'hFFFFFFFF, 16, OP_SRL, 5'd29, 64'h0000FFFF, 1);
        idle(0); drain(0);

        send(1, 64'h8000000000000000, 63, OP_SRA, 5'd1, 64'hFFFFFFFFFFFFFFFF, 1);
        send(1, 64'h0000000000000001, 63, OP_SLL, 5'd2, 64'h8000000000000000, 1);
        send(1, 64'h0123456789ABCDEF, 4,  OP_ROR, 5'd3, 64'hF0123456789ABCDE, 1);
        send(1, 64'hFFFFFFFFFFFFFFFF, 60, OP_SRL, 5'd4, 64'h000000000000000F, 1);
        send(1, 64'h4000000000000000, 62, OP_SRA, 5'd5, 64'h0000000000000001, 1);
        send(1, 64'hDEADBEEFCAFEF00D, 0,  OP_SRA, 5'd6, 64'hDEADBEEFCAFEF00D, 1);
        idle(1); drain(1);

        send(2, 64'h80, 7, OP_SRA, 5'd1, 64'hFF, 1);
        send(2, 64'h40, 6, OP_SRA, 5'd2, 64'h01, 1);
        send(2, 64'h81, 1, OP_ROR, 5'd3, 64'hC0, 1);
        send(2, 64'hFF, 7, OP_SLL, 5'd4, 64'h80, 1);
        send(2, 64'h80, 7, OP_SRL, 5'd5, 64'h01, 1);
        send(2, 64'h90, 3, OP_SRA, 5'd6, 64'hF2, 1);
        send(2, 64'h01, 1, OP_SRL, 5'd7, 64'h00, 1);
        idle(2); drain(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
